dac_wave_gen: RTL and testbench
===============================

DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

Interface
REQ-001 The block SHALL provide parameter DIV_W, default 16, width of the sample-interval divider.
REQ-002 The block SHALL provide parameter RST_CODE, default 8'h00, the sample code held after reset.
REQ-003 The block SHALL provide port clk, input, 1, the single rising-edge system clock.
REQ-004 The block SHALL provide port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-005 The block SHALL provide port en, input, 1, which enables sample generation.
REQ-006 The block SHALL provide port wave_sel, input, 2, the waveform select: 00 sawtooth, 01 square, 10 triangle, 11 reserved.
REQ-007 The block SHALL provide port step, input, 8, the unsigned phase increment per accepted sample.
REQ-008 The block SHALL provide port div, input, DIV_W, the idle clocks between samples.
REQ-009 The block SHALL provide port sample_valid, output, 1, which flags that sample_data is offered to the downstream DAC write sequencer.
REQ-010 The block SHALL provide port sample_ready, input, 1, the downstream accept signal.
REQ-011 The block SHALL provide port sample_data, output, 8, the sample code.
REQ-012 The block SHALL provide port led_out, output, 8, a copy of the last accepted sample.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT and PRESENT.
REQ-014 The FSM SHALL move from IDLE to WAIT on the first clock with en=1, and the interval counter SHALL clear on that transition.
REQ-015 In WAIT, the interval counter SHALL increment each clock, and the FSM SHALL move to PRESENT on the clock the counter reaches max(div,1)-1, so the interval is max(div,1) clocks.
REQ-016 On entry to PRESENT, sample_valid SHALL be 1 and sample_data SHALL be registered from the current phase and the wave_sel value sampled on the transition clock.
REQ-017 In PRESENT, sample_valid and sample_data SHALL hold stable until a clock edge with sample_ready=1 (the handshake).
REQ-018 On the handshake edge, sample_valid SHALL go to 0, led_out SHALL load sample_data, the phase SHALL advance, and the FSM SHALL go to WAIT if en=1 or to IDLE if en=0.
REQ-019 Deasserting en during PRESENT SHALL NOT drop sample_valid before the handshake, so no offered sample is withdrawn.
REQ-020 Deasserting en during WAIT SHALL return the FSM to IDLE on the next clock with the phase preserved.
REQ-021 Sawtooth: sample_data SHALL equal acc, where acc is an 8-bit phase with acc <= acc + step that wraps modulo 256 (255+1 gives 0).
REQ-022 Square: sample_data SHALL be 8'hFF when acc[7]=1 and 8'h00 otherwise, using the same acc update as sawtooth.
REQ-023 Triangle, going up: the triangle register SHALL take tri+step when tri+step<255 (computed 9-bit), otherwise tri SHALL be 255 and dir SHALL become down.
REQ-024 Triangle, going down: tri SHALL take tri-step when tri>step, otherwise tri SHALL be 0 and dir SHALL become up.
REQ-025 acc, tri and dir SHALL all update on every handshake regardless of wave_sel, so changing wave_sel SHALL NOT cause a phase reset.
REQ-026 step=0 SHALL hold the phase, so the output is constant while handshakes continue.
REQ-027 wave_sel=11 SHALL output 8'h80 midscale.
REQ-028 A change of div during WAIT SHALL take effect immediately; if the counter is already at or above the new max(div,1)-1, the FSM SHALL go to PRESENT on the next clock.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL force state to IDLE, the counter to 0, acc to 0, tri to 0, dir to up, sample_valid to 0, sample_data to RST_CODE and led_out to RST_CODE.
REQ-030 Reset asserted during PRESENT SHALL drop sample_valid on that edge with no handshake and no led_out update.

Configuration
REQ-031 When macro DAC_WAVE_TRI_EN is defined, the triangle register, direction flag and wave_sel=10 triangle output SHALL be compiled in.
REQ-032 When DAC_WAVE_TRI_EN is undefined, the triangle logic SHALL be absent and wave_sel=10 SHALL behave as reserved and output 8'h80.

Structure
REQ-033 Shared package dac_pkg SHALL hold the wave_sel encodings (WAVE_SAW, WAVE_SQR, WAVE_TRI, WAVE_RSV), the FSM state encoding and the constant DAC_MIDSCALE = 8'h80.
REQ-034 The block SHALL contain exactly one sub-module, dac_tri_step: a combinational next-state for tri and dir from tri, dir and step, instantiated only under DAC_WAVE_TRI_EN.

Verification
REQ-035 Sawtooth, step=64, div=3, sample_ready tied 1: samples SHALL be 0,64,128,192,0, with sample_valid high for 1 clock every 4 clocks.
REQ-036 Square, step=64: samples SHALL be 00,00,FF,FF,00.
REQ-037 Triangle, step=100: samples SHALL be 0,100,200,255,155,55,0,100, with dir reversing at 255 and at 0.
REQ-038 Backpressure, sample_ready held 0 for 10 clocks and en dropped mid-hold: sample_valid and sample_data SHALL stay constant; after ready=1, one handshake SHALL occur, led_out SHALL update and the FSM SHALL go to IDLE.
REQ-039 rst=1 pulsed during PRESENT: on the next clock sample_valid SHALL be 0, sample_data and led_out SHALL be 8'h00, and the first post-reset sample SHALL be 0.
REQ-040 Build without DAC_WAVE_TRI_EN and set wave_sel=10: every sample SHALL be 8'h80.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared encodings for the DAC waveform generator: wave select, FSM states,
// triangle direction and the midscale code.
package dac_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'b00,
    WAVE_SQR = 2'b01,
    WAVE_TRI = 2'b10,
    WAVE_RSV = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    PRESENT = 2'b10
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [7:0] DAC_MIDSCALE = 8'h80;

endpackage

// File: rtl/dac_tri_step.sv
// Combinational next value of the triangle register and its direction flag.
module dac_tri_step
  import dac_pkg::*;
(
  input  logic [7:0] tri_cur,
  input  dir_e       dir_cur,
  input  logic [7:0] step,
  output logic [7:0] tri_nxt,
  output dir_e       dir_nxt
);

  logic [8:0] sum;
  assign sum = {1'b0, tri_cur} + {1'b0, step};

  // Clamp at the rails and reverse direction there.
  always_comb begin
    tri_nxt = tri_cur;
    dir_nxt = dir_cur;
    if (dir_cur == DIR_UP) begin
      if (sum < 9'd255) begin
        tri_nxt = sum[7:0];
      end else begin
        tri_nxt = 8'hFF;
        dir_nxt = DIR_DOWN;
      end
    end else begin
      if (tri_cur > step) begin
        tri_nxt = tri_cur - step;
      end else begin
        tri_nxt = 8'h00;
        dir_nxt = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/dac_wave_gen.sv
// Paced waveform sample generator with a valid/ready handshake to the DAC writer.
// Define DAC_WAVE_TRI_EN to compile in the triangle waveform.
module dac_wave_gen
  import dac_pkg::*;
#(
  parameter int unsigned DIV_W    = 16,
  parameter logic [7:0]  RST_CODE = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       wave_sel,
  input  logic [7:0]       step,
  input  logic [DIV_W-1:0] div,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [7:0]       sample_data,
  output logic [7:0]       led_out
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] limit;
  logic [7:0]       acc_q;
  logic [7:0]       sample_c;
  logic             load_c;
  logic             hs_c;

`ifdef DAC_WAVE_TRI_EN
  logic [7:0] tri_q, tri_d;
  dir_e       dir_q, dir_d;

  dac_tri_step u_tri_step (
    .tri_cur (tri_q),
    .dir_cur (dir_q),
    .step    (step),
    .tri_nxt (tri_d),
    .dir_nxt (dir_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tri_q <= 8'h00;
      dir_q <= DIR_UP;
    end else if (hs_c) begin
      tri_q <= tri_d;
      dir_q <= dir_d;
    end
  end
`endif

  // Interval of max(div,1) clocks means the terminal count is max(div,1)-1.
  assign limit = (div == '0) ? '0 : div - DIV_W'(1);

  always_comb begin
    case (wave_e'(wave_sel))
      WAVE_SAW: sample_c = acc_q;
      WAVE_SQR: sample_c = {8{acc_q[7]}};
`ifdef DAC_WAVE_TRI_EN
      WAVE_TRI: sample_c = tri_q;
`endif
      default:  sample_c = DAC_MIDSCALE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    hs_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (cnt_q >= limit) begin
          state_d = PRESENT;
          load_c  = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      PRESENT: begin
        // en is ignored until accepted so an offered sample is never withdrawn.
        if (sample_ready) begin
          hs_c    = 1'b1;
          cnt_d   = '0;
          state_d = en ? WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= 8'h00;
      sample_valid <= 1'b0;
      sample_data  <= RST_CODE;
      led_out      <= RST_CODE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_c) begin
        sample_valid <= 1'b1;
        sample_data  <= sample_c;
      end
      if (hs_c) begin
        sample_valid <= 1'b0;
        led_out      <= sample_data;
        acc_q        <= acc_q + step;
      end
    end
  end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Scoreboard testbench for dac_wave_gen; expected samples are queued per scenario.
module tb_dac_wave_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  wave_sel;
  logic [7:0]  step;
  logic [15:0] div;
  logic        sample_ready;
  logic        sample_valid;
  logic [7:0]  sample_data;
  logic [7:0]  led_out;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  dac_wave_gen dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .wave_sel     (wave_sel),
    .step         (step),
    .div          (div),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .led_out      (led_out)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for sample_valid at a falling edge; returns data and cycles waited.
  task automatic get_sample(input int budget, output logic [7:0] d, output int waited,
                            output bit ok);
    ok = 1'b0; waited = 0; d = 8'h00;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited++;
      if (sample_valid === 1'b1) begin
        d = sample_data; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; wave_sel = 2'b00; step = 8'd0; div = 16'd0; sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", sample_valid);
    else pass_cnt++;
    total_cnt++;
    if (sample_data !== 8'h00) $display("FAIL reset_data: got %h want 00", sample_data);
    else pass_cnt++;
    total_cnt++;
    if (led_out !== 8'h00) $display("FAIL reset_led: got %h want 00", led_out);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_saw();
    logic [7:0] v [0:4];
    logic [7:0] d, e;
    int w; bit ok;
    v = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd0};
    do_reset();
    wave_sel = 2'b00; step = 8'd64; div = 16'd3; sample_ready = 1'b1;
    foreach (v[i]) exp_q.push_back(v[i]);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_sample(40, d, w, ok);
      e = exp_q.pop_front();
      total_cnt++;
      if (!ok || d !== e) $display("FAIL saw_sample%0d: got %h (seen=%0d) want %h", i, d, ok, e);
      else pass_cnt++;
      if (i > 0) begin
        total_cnt++;
        if (w !== 4) $display("FAIL saw_period%0d: got %0d clocks want 4", i, w);
        else pass_cnt++;
      end
      if (i == 4) begin
        total_cnt++;
        if (led_out !== 8'd192) $display("FAIL saw_led: got %h want c0", led_out);
        else pass_cnt++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_square();
    logic [7:0] v [0:4];
    logic [7:0] d, e;
    int w; bit ok;
    v = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    do_reset();
    wave_sel = 2'b01; step = 8'd64; div = 16'd2; sample_ready = 1'b1;
    foreach (v[i]) exp_q.push_back(v[i]);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_sample(40, d, w, ok);
      e = exp_q.pop_front();
      total_cnt++;
      if (!ok || d !== e) $display("FAIL sqr_sample%0d: got %h (seen=%0d) want %h", i, d, ok, e);
      else pass_cnt++;
    end
    en = 1'b0;
  endtask

  task automatic test_triangle();
    logic [7:0] v [0:7];
    logic [7:0] d, e;
    int w; bit ok;
`ifdef DAC_WAVE_TRI_EN
    v = '{8'd0, 8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};
`else
    v = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
`endif
    do_reset();
    wave_sel = 2'b10; step = 8'd100; div = 16'd1; sample_ready = 1'b1;
    foreach (v[i]) exp_q.push_back(v[i]);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      get_sample(40, d, w, ok);
      e = exp_q.pop_front();
      total_cnt++;
      if (!ok || d !== e) $display("FAIL tri_sample%0d: got %h (seen=%0d) want %h", i, d, ok, e);
      else pass_cnt++;
    end
    en = 1'b0;
  endtask

  task automatic test_reserved_and_step0();
    logic [7:0] d, e;
    int w; bit ok;
    do_reset();
    wave_sel = 2'b11; step = 8'd37; div = 16'd2; sample_ready = 1'b1;
    repeat (3) exp_q.push_back(8'h80);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_sample(40, d, w, ok);
      e = exp_q.pop_front();
      total_cnt++;
      if (!ok || d !== e) $display("FAIL rsv_sample%0d: got %h (seen=%0d) want %h", i, d, ok, e);
      else pass_cnt++;
    end
    // Phase is now 3*37=111; step=0 must hold it there on the sawtooth.
    @(negedge clk);
    wave_sel = 2'b00; step = 8'd0;
    repeat (3) exp_q.push_back(8'd111);
    for (int i = 0; i < 3; i++) begin
      get_sample(40, d, w, ok);
      e = exp_q.pop_front();
      total_cnt++;
      if (!ok || d !== e) $display("FAIL step0_sample%0d: got %h (seen=%0d) want %h", i, d, ok, e);
      else pass_cnt++;
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] d, e;
    int w; bit ok; bit seen;
    do_reset();
    wave_sel = 2'b00; step = 8'd64; div = 16'd2; sample_ready = 1'b1;
    exp_q.push_back(8'd0); exp_q.push_back(8'd64);
    en = 1'b1;
    get_sample(40, d, w, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || d !== e) $display("FAIL bp_first: got %h (seen=%0d) want %h", d, ok, e);
    else pass_cnt++;
    @(negedge clk);
    sample_ready = 1'b0;
    get_sample(40, d, w, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || d !== e) $display("FAIL bp_offer: got %h (seen=%0d) want %h", d, ok, e);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) en = 1'b0;
      total_cnt++;
      if (sample_valid !== 1'b1 || sample_data !== e)
        $display("FAIL bp_hold%0d: got valid=%b data=%h want valid=1 data=%h",
                 i, sample_valid, sample_data, e);
      else pass_cnt++;
    end
    sample_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (sample_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", sample_valid);
    else pass_cnt++;
    total_cnt++;
    if (led_out !== 8'd64) $display("FAIL bp_led: got %h want 40", led_out);
    else pass_cnt++;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (sample_valid === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL bp_idle: got valid seen=%0d want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_present();
    logic [7:0] d, e;
    int w; bit ok;
    do_reset();
    wave_sel = 2'b00; step = 8'd64; div = 16'd2; sample_ready = 1'b1;
    exp_q.push_back(8'd0); exp_q.push_back(8'd64); exp_q.push_back(8'd128);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_sample(40, d, w, ok);
      e = exp_q.pop_front();
      if (i == 1) begin
        @(negedge clk);
        sample_ready = 1'b0;
      end
      total_cnt++;
      if (!ok || d !== e) $display("FAIL rp_sample%0d: got %h (seen=%0d) want %h", i, d, ok, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (led_out !== 8'd64) $display("FAIL rp_led_before: got %h want 40", led_out);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (sample_valid !== 1'b0 || sample_data !== 8'h00 || led_out !== 8'h00)
      $display("FAIL rp_after_rst: got valid=%b data=%h led=%h want 0/00/00",
               sample_valid, sample_data, led_out);
    else pass_cnt++;
    sample_ready = 1'b1;
    exp_q.push_back(8'd0);
    get_sample(40, d, w, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || d !== e) $display("FAIL rp_first_post: got %h (seen=%0d) want %h", d, ok, e);
    else pass_cnt++;
    en = 1'b0;
  endtask

  task automatic test_div_change();
    logic [7:0] d, e;
    int w; bit ok; bit seen;
    do_reset();
    wave_sel = 2'b00; step = 8'd10; div = 16'd0; sample_ready = 1'b1;
    exp_q.push_back(8'd0); exp_q.push_back(8'd10);
    en = 1'b1;
    get_sample(40, d, w, ok);
    e = exp_q.pop_front();
    get_sample(40, d, w, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || d !== e || w !== 2)
      $display("FAIL div0_interval: got data=%h clocks=%0d want data=%h clocks=2", d, w, e);
    else pass_cnt++;
    div = 16'd20;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (sample_valid === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL div20_early: got valid seen=%0d want 0", seen);
    else pass_cnt++;
    div = 16'd2;
    @(negedge clk);
    total_cnt++;
    if (sample_valid !== 1'b1 || sample_data !== 8'd20)
      $display("FAIL div_shrink: got valid=%b data=%h want valid=1 data=14",
               sample_valid, sample_data);
    else pass_cnt++;
    @(negedge clk);
    en = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (sample_valid === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL wait_abort: got valid seen=%0d want 0", seen);
    else pass_cnt++;
    exp_q.push_back(8'd30);
    en = 1'b1;
    get_sample(40, d, w, ok);
    e = exp_q.pop_front();
    total_cnt++;
    if (!ok || d !== e) $display("FAIL phase_kept: got %h (seen=%0d) want %h", d, ok, e);
    else pass_cnt++;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saw();
    test_square();
    test_triangle();
    test_reserved_and_step0();
    test_backpressure();
    test_reset_present();
    test_div_change();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
